// File: rtl/flash_adc_pkg.sv
// Shared types and widths for the 3-bit flash ADC decoder and its conversion sequencer.
package flash_adc_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned ACC_W  = 6;
  localparam int unsigned OSR_W  = 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } state_e;

  // Number of captures per burst for a given oversampling exponent.
  function automatic logic [CNT_W-1:0] osr_count(input logic [OSR_W-1:0] osr_log2);
    return CNT_W'(1) << osr_log2;
  endfunction

endpackage

// File: rtl/flash_adc_seq_if.sv
// Result valid/ready port between the conversion sequencer and downstream logic.
interface flash_adc_seq_if;
  import flash_adc_pkg::*;

  logic [CODE_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);

endinterface

// File: rtl/flash_adc_accum.sv
// Burst accumulator: sums captured codes, flags the terminal capture and shift-divides the total.
module flash_adc_accum
  import flash_adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic [OSR_W-1:0]  osr_log2_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              last_o,
  output logic [CODE_W-1:0] result_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum      = acc_q + ACC_W'(code_i);
    last_o   = (cnt_q + CNT_W'(1)) == osr_count(osr_log2_i);
    result_o = CODE_W'(sum >> osr_log2_i);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flash_adc_seq.sv
// Conversion sequencer: paces sample/convert phases, captures decoder codes and
// presents the oversampled average on a valid/ready port.
module flash_adc_seq
  import flash_adc_pkg::*;
#(
  parameter int unsigned SAMP_W      = 4,
  parameter int unsigned EOC_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic [SAMP_W-1:0] samp_cycles,
  input  logic [OSR_W-1:0]  osr_log2,
  output logic              samp,
  input  logic [CODE_W-1:0] dec_code,
  input  logic              dec_eoc,
  flash_adc_seq_if.master   res,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
);

  localparam int unsigned TO_W = (EOC_TIMEOUT > 1) ? $clog2(EOC_TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [SAMP_W-1:0]  samp_len_q, samp_len_d;
  logic [OSR_W-1:0]   osr_q, osr_d;
  logic [SAMP_W-1:0]  tmr_q, tmr_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [CODE_W-1:0]  res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               samp_q, samp_d;

  logic               acc_clear, acc_add, acc_last, load;
  logic [CODE_W-1:0]  acc_result;

  flash_adc_accum u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (acc_clear),
    .add_i      (acc_add),
    .osr_log2_i (osr_q),
    .code_i     (dec_code),
    .last_o     (acc_last),
    .result_o   (acc_result)
  );

  always_comb begin
    state_d    = state_q;
    samp_len_d = samp_len_q;
    osr_d      = osr_q;
    tmr_d      = tmr_q;
    to_d       = to_q;
    timeout_d  = timeout_q;
    acc_clear  = 1'b0;
    acc_add    = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start || cont) begin
          state_d    = SAMPLE;
          samp_len_d = (samp_cycles == '0) ? SAMP_W'(1) : samp_cycles;
          osr_d      = osr_log2;
          tmr_d      = '0;
          acc_clear  = 1'b1;
        end
      end
      SAMPLE: begin
        if (tmr_q == samp_len_q - SAMP_W'(1)) begin
          state_d = CONVERT;
          to_d    = '0;
        end else begin
          tmr_d = tmr_q + SAMP_W'(1);
        end
      end
      CONVERT: begin
        if (dec_eoc) begin
          acc_add = 1'b1;
          tmr_d   = '0;
          if (acc_last) begin
            load      = 1'b1;
            acc_clear = 1'b1;
            if (cont) begin
              state_d    = SAMPLE;
              samp_len_d = (samp_cycles == '0) ? SAMP_W'(1) : samp_cycles;
              osr_d      = osr_log2;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = SAMPLE;
          end
        end else if (to_q == TO_W'(EOC_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          acc_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Drain first, then a fresh load re-asserts valid; overrun only if the old word was not taken.
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    if (res_valid_q && res.res_ready) res_valid_d = 1'b0;
    if (load) begin
      res_data_d  = acc_result;
      res_valid_d = 1'b1;
      if (res_valid_q && !res.res_ready) overrun_d = 1'b1;
    end

    // samp is registered from the next state so it tracks the state register exactly.
    samp_d = (state_d != CONVERT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      samp_len_q  <= '0;
      osr_q       <= '0;
      tmr_q       <= '0;
      to_q        <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      samp_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      samp_len_q  <= samp_len_d;
      osr_q       <= osr_d;
      tmr_q       <= tmr_d;
      to_q        <= to_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      samp_q      <= samp_d;
    end
  end

  assign samp          = samp_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;
  assign res.res_data  = res_data_q;
  assign res.res_valid = res_valid_q;

endmodule

// File: tb/tb_flash_adc_seq.sv
// Scoreboard bench for flash_adc_seq with a behavioural decoder model feeding queued codes.
module tb_flash_adc_seq;
  import flash_adc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [3:0] samp_cycles;
  logic [1:0] osr_log2;
  logic       samp;
  logic [2:0] dec_code;
  logic       dec_eoc;
  logic       busy;
  logic       overrun;
  logic       timeout;

  flash_adc_seq_if rif ();

  flash_adc_seq #(.SAMP_W(4), .EOC_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .samp_cycles (samp_cycles),
    .osr_log2    (osr_log2),
    .samp        (samp),
    .dec_code    (dec_code),
    .dec_eoc     (dec_eoc),
    .res         (rif),
    .busy        (busy),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [2:0] sb[$];
  logic [2:0] codes[$];
  logic eoc_en = 1'b1;
  int   eoc_count = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Decoder model: eoc rises one cycle after it latches on samp=0, carrying the next queued code.
  initial begin
    int lowcnt;
    lowcnt   = 0;
    dec_eoc  = 1'b0;
    dec_code = '0;
    forever begin
      @(negedge clk);
      if (samp === 1'b0) lowcnt++;
      else lowcnt = 0;
      if (eoc_en && lowcnt >= 2) begin
        if (!dec_eoc) begin
          if (codes.size() > 0) dec_code = codes.pop_front();
          else dec_code = '0;
          eoc_count++;
        end
        dec_eoc = 1'b1;
      end else begin
        dec_eoc = 1'b0;
      end
    end
  end

  // Monitor: every accepted transfer is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && rif.res_valid === 1'b1 && rif.res_ready === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got data %0d, expected no transfer", rif.res_data);
        end else begin
          check("sb_data", int'(rif.res_data), int'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic shot(input string nm, input int s, input int osr, input int exp_data, input int exp_lat);
    int e0, t_rise, rises;
    logic prev;
    samp_cycles = 4'(s);
    osr_log2    = 2'(osr);
    sb.push_back(3'(exp_data));
    start = 1'b1;
    @(negedge clk);
    e0     = cyc;
    start  = 1'b0;
    rises  = 0;
    t_rise = -1000;
    prev   = 1'b0;
    for (int i = 0; i < exp_lat + 12; i++) begin
      if (rif.res_valid && !prev) begin
        rises++;
        if (t_rise < 0) t_rise = cyc;
      end
      prev = rif.res_valid;
      @(negedge clk);
    end
    check({nm, "_latency"}, t_rise - e0, exp_lat);
    check({nm, "_valid_pulses"}, rises, 1);
    check({nm, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic wait_valid(input string nm, input int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rif.res_valid) begin
        ok = 1;
        break;
      end
    end
    check({nm, "_valid_seen"}, ok, 1);
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check({nm, "_idle_seen"}, ok, 1);
  endtask

  initial begin
    int e0, t_to, vcount, ok, c0;
    start         = 1'b0;
    cont          = 1'b0;
    samp_cycles   = '0;
    osr_log2      = '0;
    rif.res_ready = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_samp", int'(samp), 1);
    check("rst_res_valid", int'(rif.res_valid), 0);
    check("rst_res_data", int'(rif.res_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single shots, averaging, and samp_cycles=0 treated as 1
    rif.res_ready = 1'b1;
    codes.push_back(3'd5);
    shot("single", 2, 0, 5, 4);
    codes.push_back(3'd7);
    shot("samp0", 0, 0, 7, 3);
    codes.push_back(3'd3); codes.push_back(3'd4); codes.push_back(3'd4); codes.push_back(3'd6);
    shot("avg4", 3, 2, 4, 20);
    codes.push_back(3'd6); codes.push_back(3'd3);
    shot("avg2", 1, 1, 4, 6);

    // Continuous, downstream stalled: second result overwrites first
    rif.res_ready = 1'b0;
    codes.push_back(3'd1); codes.push_back(3'd2);
    samp_cycles = 4'd1;
    osr_log2    = 2'd0;
    cont        = 1'b1;
    wait_valid("cont_stall", 20);
    cont = 1'b0;
    wait_idle("cont_stall", 20);
    check("cont_stall_data", int'(rif.res_data), 2);
    check("cont_stall_overrun", int'(overrun), 1);
    check("cont_stall_valid", int'(rif.res_valid), 1);
    sb.push_back(3'd2);
    rif.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("cont_stall_drained", int'(rif.res_valid), 0);
    check("cont_stall_overrun_sticky", int'(overrun), 1);

    // Continuous, downstream ready: both results transferred, no overrun
    apply_reset(2);
    check("reset_clears_overrun", int'(overrun), 0);
    codes.push_back(3'd1); codes.push_back(3'd2);
    sb.push_back(3'd1); sb.push_back(3'd2);
    cont = 1'b1;
    wait_valid("cont_ready", 20);
    cont = 1'b0;
    wait_idle("cont_ready", 20);
    repeat (3) @(negedge clk);
    check("cont_ready_overrun", int'(overrun), 0);
    check("cont_ready_sb_drained", sb.size(), 0);

    // Missing EOC
    eoc_en      = 1'b0;
    samp_cycles = 4'd1;
    osr_log2    = 2'd0;
    start       = 1'b1;
    @(negedge clk);
    e0     = cyc;
    start  = 1'b0;
    t_to   = -1000;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (timeout && t_to < 0) t_to = cyc;
      if (rif.res_valid) vcount++;
      @(negedge clk);
    end
    check("timeout_latency", t_to - e0, 5);
    check("timeout_no_valid", vcount, 0);
    check("timeout_busy", int'(busy), 0);
    check("timeout_sticky", int'(timeout), 1);
    eoc_en = 1'b1;

    // Reset mid-burst: three captures of 7 must not leak into the next average
    for (int i = 0; i < 8; i++) codes.push_back(3'd7);
    c0          = eoc_count;
    samp_cycles = 4'd2;
    osr_log2    = 2'd3;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok    = 0;
    for (int i = 0; i < 60; i++) begin
      if (eoc_count == c0 + 3) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("midrst_third_capture", ok, 1);
    @(negedge clk);
    apply_reset(2);
    check("midrst_busy", int'(busy), 0);
    check("midrst_samp", int'(samp), 1);
    check("midrst_timeout_cleared", int'(timeout), 0);
    check("midrst_no_valid", int'(rif.res_valid), 0);
    codes.delete();
    for (int i = 0; i < 8; i++) codes.push_back(3'(i));
    shot("midrst_avg8", 2, 3, 3, 32);

    check("sb_empty_at_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
